// File: rtl/memory_stage.sv
// memory_stage: MEM stage of a 5-stage RV32I pipeline.
//
// Drives a req/ack data-memory port, aligns store data onto byte lanes,
// extracts and extends load data, and owns the MEM/WB pipeline register.
// Upstream stages are held via stall_m_o while an access is outstanding.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   When defined, misaligned half/word accesses are not sent to memory.
//   They complete in one cycle with the RF write suppressed, and the
//   extra output misaligned_w_o flags the slot.
//   When undefined, low address bits only select lanes and every access
//   proceeds as if aligned.

module memory_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  // EX/MEM inputs
  input  logic                      valid_m_i,
  input  logic                      reg_write_m_i,
  input  logic [1:0]                result_src_m_i,
  input  logic                      mem_write_m_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_m_i,
  input  logic [2:0]                funct3_m_i,
  // data-memory port
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_ack_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  // hazard
  output logic                      stall_m_o,
  // MEM/WB outputs
  output logic                      valid_w_o,
  output logic                      reg_write_w_o,
  output logic [1:0]                result_src_w_o,
  output logic [DATA_WIDTH-1:0]     alu_result_w_o,
  output logic [DATA_WIDTH-1:0]     read_data_w_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_w_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                      misaligned_w_o,
`endif
  output logic [DATA_WIDTH-1:0]     pc_plus_4_w_o
);

  localparam logic [1:0] RES_LOAD = 2'b01;

  // Access FSM states.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;

  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        req;
  logic        stall;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [1:0]  lane;

  assign lane = alu_result_m_i[1:0];

  // Classify the slot: memory access or not, and its access size.
  always_comb begin
    mem_op  = valid_m_i & (mem_write_m_i | (result_src_m_i == RES_LOAD));
    // funct3[1:0] gives the size for both loads and stores; unsigned loads
    // only differ in bit 2, and every other encoding behaves as a word.
    is_byte = (funct3_m_i[1:0] == 2'b00);
    is_half = (funct3_m_i[1:0] == 2'b01);
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // A half needs addr[0]==0 and a word needs addr[1:0]==0.
  always_comb begin
    misaligned = mem_op & ((is_half & lane[0]) |
                           (~is_byte & ~is_half & (lane != 2'b00)));
  end
`else
  // Without trapping every access is treated as aligned.
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Request/stall generation; reset drops the request at once, even mid-WAIT.
  always_comb begin
    req   = ~rst & (((state_q == IDLE) & mem_op & ~misaligned) |
                    (state_q == WAIT));
    stall = req & ~dmem_ack_i;
  end

  // Next-state logic: wait in WAIT until the memory acknowledges.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves state_d
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (req & ~dmem_ack_i) state_d = WAIT;
      WAIT:    if (dmem_ack_i)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Store lane alignment: replicate the datum and enable the addressed lanes.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = rs2_data_m_i;
    if (mem_write_m_i) begin
      if (is_byte) begin
        store_be    = 4'b0001 << lane;
        store_wdata = {4{rs2_data_m_i[7:0]}};
      end else if (is_half) begin
        store_be    = lane[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{rs2_data_m_i[15:0]}};
      end
    end
  end

  // Load extraction and extension from the returned word.
  always_comb begin
    load_byte = dmem_rdata_i[7:0];
    case (lane)
      2'b00:   load_byte = dmem_rdata_i[7:0];
      2'b01:   load_byte = dmem_rdata_i[15:8];
      2'b10:   load_byte = dmem_rdata_i[23:16];
      default: load_byte = dmem_rdata_i[31:24];
    endcase
    load_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_m_i)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // Memory port and hazard outputs, all combinational.
  always_comb begin
    dmem_req_o   = req;
    dmem_we_o    = req & mem_write_m_i;
    dmem_addr_o  = {alu_result_m_i[31:2], 2'b00};
    dmem_be_o    = store_be;
    dmem_wdata_o = store_wdata;
    stall_m_o    = stall;
  end

  // MEM/WB register: bubble while stalled, otherwise capture the slot.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain flops, not a memory array, so resetting every
    // field is cheap and keeps the W outputs defined out of reset.
    if (rst) begin
      valid_w_o      <= 1'b0;
      reg_write_w_o  <= 1'b0;
      result_src_w_o <= 2'b00;
      alu_result_w_o <= '0;
      read_data_w_o  <= '0;
      rd_addr_w_o    <= '0;
      pc_plus_4_w_o  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_w_o <= 1'b0;
`endif
    end else if (stall) begin
      valid_w_o      <= 1'b0;
      reg_write_w_o  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_w_o <= 1'b0;
`endif
    end else begin
      valid_w_o      <= valid_m_i;
      reg_write_w_o  <= reg_write_m_i & valid_m_i & ~misaligned;
      result_src_w_o <= result_src_m_i;
      alu_result_w_o <= alu_result_m_i;
      read_data_w_o  <= load_data;
      rd_addr_w_o    <= rd_addr_m_i;
      pc_plus_4_w_o  <= pc_plus_4_m_i;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_w_o <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of lane selection, extension and stall timing.

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m_i;
  logic        reg_write_m_i;
  logic [1:0]  result_src_m_i;
  logic        mem_write_m_i;
  logic [31:0] alu_result_m_i;
  logic [31:0] rs2_data_m_i;
  logic [4:0]  rd_addr_m_i;
  logic [31:0] pc_plus_4_m_i;
  logic [2:0]  funct3_m_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_m_o;
  logic        valid_w_o;
  logic        reg_write_w_o;
  logic [1:0]  result_src_w_o;
  logic [31:0] alu_result_w_o;
  logic [31:0] read_data_w_o;
  logic [4:0]  rd_addr_w_o;
  logic [31:0] pc_plus_4_w_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned_w_o;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_m_i      (valid_m_i),
    .reg_write_m_i  (reg_write_m_i),
    .result_src_m_i (result_src_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .alu_result_m_i (alu_result_m_i),
    .rs2_data_m_i   (rs2_data_m_i),
    .rd_addr_m_i    (rd_addr_m_i),
    .pc_plus_4_m_i  (pc_plus_4_m_i),
    .funct3_m_i     (funct3_m_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_m_o      (stall_m_o),
    .valid_w_o      (valid_w_o),
    .reg_write_w_o  (reg_write_w_o),
    .result_src_w_o (result_src_w_o),
    .alu_result_w_o (alu_result_w_o),
    .read_data_w_o  (read_data_w_o),
    .rd_addr_w_o    (rd_addr_w_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned_w_o (misaligned_w_o),
`endif
    .pc_plus_4_w_o  (pc_plus_4_w_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Access size in bytes from funct3 (any non-byte, non-half code is a word).
  function automatic int size_of(input logic [2:0] f3);
    int s;
    s = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    return s;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = size_of(f3);
    return TRAP && (s > 1) && ((a % s) != 0);
  endfunction

  function automatic logic [3:0] model_be(input bit store, input logic [2:0] f3, input logic [31:0] a);
    int s;
    int base;
    logic [3:0] m;
    s = size_of(f3);
    if (!store || s == 4) return 4'hF;
    base = (a % 4) / s * s;            // first byte of the addressed lane
    m = 4'h0;
    for (int i = 0; i < s; i++) m[base + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = size_of(f3);
    if (s == 1) return (d % 256) * 32'h0101_0101;
    if (s == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int s;
    longint unsigned v;
    longint unsigned span;
    s    = size_of(f3);
    span = longint'(1) << (8 * s);
    v    = (longint'(w) >> (8 * ((a % 4) / s * s))) % span;
    if (s < 4 && f3[2] == 1'b0 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  // Apply one instruction, hold it through any wait cycles, and check
  // the port during each cycle and the MEM/WB capture afterwards.
  task automatic apply_op(input bit v, input bit rw, input logic [1:0] rs, input bit mw,
                          input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [2:0] f3, input int waits,
                          input logic [31:0] rword);
    bit mop;
    bit mis;
    bit req_exp;
    int w;
    valid_m_i = v; reg_write_m_i = rw; result_src_m_i = rs; mem_write_m_i = mw;
    alu_result_m_i = alu; rs2_data_m_i = rs2; rd_addr_m_i = rd; pc_plus_4_m_i = pc;
    funct3_m_i = f3;
    mop     = v && (mw || rs == 2'b01);
    mis     = mop && model_misaligned(f3, alu);
    req_exp = mop && !mis;
    w       = req_exp ? waits : 0;
    for (int c = 0; c <= w; c++) begin
      if (c == w) begin
        // A stray ack with no request must be ignored.
        dmem_ack_i   = req_exp ? 1'b1 : 1'($urandom % 2);
        dmem_rdata_i = rword;
      end else begin
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = $urandom;
      end
      @(negedge clk);
      check("req", dmem_req_o, req_exp);
      check("stall", stall_m_o, req_exp && c < w);
      if (req_exp) begin
        check("addr", dmem_addr_o, alu & 32'hFFFF_FFFC);
        check("we", dmem_we_o, mw);
        check("be", dmem_be_o, model_be(mw, f3, alu));
        if (mw) check("wdata", dmem_wdata_o, model_wdata(f3, rs2));
      end
      @(posedge clk); #1;
      if (c < w) begin
        check("bubble_valid", valid_w_o, 1'b0);
        check("bubble_rw", reg_write_w_o, 1'b0);
      end
    end
    dmem_ack_i = 1'b0;
    check("valid_w", valid_w_o, v);
    check("reg_write_w", reg_write_w_o, rw && v && !mis);
    check("result_src_w", result_src_w_o, rs);
    check("alu_result_w", alu_result_w_o, alu);
    check("rd_addr_w", rd_addr_w_o, rd);
    check("pc_plus_4_w", pc_plus_4_w_o, pc);
    if (req_exp && !mw) check("read_data_w", read_data_w_o, model_load(f3, alu, rword));
`ifdef MEM_MISALIGN_TRAP_EN
    check("misaligned_w", misaligned_w_o, mis);
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid_m_i = 1'b0; reg_write_m_i = 1'b0; result_src_m_i = 2'b00; mem_write_m_i = 1'b0;
    alu_result_m_i = '0; rs2_data_m_i = '0; rd_addr_m_i = '0; pc_plus_4_m_i = '0;
    funct3_m_i = 3'b000; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_w", valid_w_o, 1'b0);
    check("rst_reg_write_w", reg_write_w_o, 1'b0);
    check("rst_alu_result_w", alu_result_w_o, 32'h0);
    check("rst_read_data_w", read_data_w_o, 32'h0);
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_stall", stall_m_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // SW, zero-wait.
    apply_op(1, 0, 2'b00, 1, 32'h1000_0008, 32'hDEAD_BEEF, 5'd0, 32'h100, 3'b010, 0, 32'h0);
    // LB at lane 3, two wait cycles.
    apply_op(1, 1, 2'b01, 0, 32'h1000_0003, 32'h0, 5'd3, 32'h104, 3'b000, 2, 32'h80FF_1234);
    check("lb_value", read_data_w_o, 32'hFFFF_FF80);
    // SH upper half, then LHU from the same address.
    apply_op(1, 0, 2'b00, 1, 32'h1000_0002, 32'h0000_ABCD, 5'd0, 32'h108, 3'b001, 1, 32'h0);
    apply_op(1, 1, 2'b01, 0, 32'h1000_0002, 32'h0, 5'd4, 32'h10C, 3'b101, 0, 32'hABCD_0000);
    check("lhu_value", read_data_w_o, 32'h0000_ABCD);
    // ADD passthrough, then an empty slot.
    apply_op(1, 1, 2'b00, 0, 32'h55, 32'h0, 5'd7, 32'h110, 3'b000, 0, 32'h0);
    apply_op(0, 1, 2'b00, 0, 32'h66, 32'h0, 5'd8, 32'h114, 3'b000, 0, 32'h0);
    // LW at a misaligned address: trapped, or treated as the aligned word.
    apply_op(1, 1, 2'b01, 0, 32'h1000_0002, 32'h0, 5'd9, 32'h118, 3'b010, 1, 32'h1234_5678);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [1:0] rs;
      logic [2:0] f3;
      bit mw;
      kind = $urandom % 4;
      mw   = (kind == 3);
      rs   = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
      f3   = (kind == 3) ? 3'($urandom % 3) : 3'($urandom % 8);
      apply_op(($urandom % 8) != 0, kind != 3, rs, mw, $urandom, $urandom, 5'($urandom),
               $urandom, f3, $urandom % 4, $urandom);
    end

    // Reset while a load waits: request drops, late ack ignored.
    valid_m_i = 1'b1; reg_write_m_i = 1'b1; result_src_m_i = 2'b01; mem_write_m_i = 1'b0;
    alu_result_m_i = 32'h2000_0010; funct3_m_i = 3'b010; dmem_ack_i = 1'b0;
    @(negedge clk);
    check("wait_req", dmem_req_o, 1'b1);
    check("wait_stall", stall_m_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_req", dmem_req_o, 1'b0);
    check("rstw_stall", stall_m_o, 1'b0);
    check("rstw_valid_w", valid_w_o, 1'b0);
    check("rstw_alu_result_w", alu_result_w_o, 32'h0);
    check("rstw_pc_plus_4_w", pc_plus_4_w_o, 32'h0);
    @(negedge clk);
    valid_m_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_req", dmem_req_o, 1'b0);
    check("late_ack_stall", stall_m_o, 1'b0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    check("late_ack_valid_w", valid_w_o, 1'b0);
    @(negedge clk);
    check("idle_after_rst", dmem_req_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
